// File: rtl/phy_pkg.sv
// Shared constants, state encoding and helpers for the PHY transmit path.
package phy_pkg;

  localparam logic [7:0] COM_CHAR_DEFAULT = 8'hBC;
  localparam int         FRAME_BITS       = 32;
  localparam int         LANES            = 4;
  localparam int         BYTE_BITS        = 8;
  localparam int         CNT_W            = $clog2(FRAME_BITS);

  typedef enum logic {
    SYNC = 1'b0,
    DATA = 1'b1
  } phy_state_e;

  // One COM character on every lane.
  function automatic logic [FRAME_BITS-1:0] com_frame(input logic [BYTE_BITS-1:0] com);
    return {LANES{com}};
  endfunction

endpackage

// File: rtl/phy_tx_frame_builder.sv
// Combinational frame assembly: lane 0 in the top byte, COM for invalid lanes
// or while synchronising.
module phy_tx_frame_builder
  import phy_pkg::*;
#(
  parameter logic [7:0] COM_CHAR = COM_CHAR_DEFAULT
) (
  input  logic [LANES-1:0][BYTE_BITS-1:0] lane_data_i,
  input  logic [LANES-1:0]                lane_valid_i,
  input  phy_state_e                      state_i,
  output logic [FRAME_BITS-1:0]           frame_o
);

  // NOTE: frame_o gets a full default before any conditional update, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    frame_o = com_frame(COM_CHAR);
    if (state_i == DATA) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid_i[i]) begin
          frame_o[FRAME_BITS-1-BYTE_BITS*i -: BYTE_BITS] = lane_data_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/phy_tx_serializer.sv
// 4-lane byte-to-serial transmitter, one 32-bit frame per 32 clk_32f cycles.
// Optional COM preamble after reset is enabled by `define PHY_TX_SYNC_PREAMBLE_EN.
module phy_tx_serializer
  import phy_pkg::*;
#(
  parameter int         SYNC_FRAMES = 2,
  parameter logic [7:0] COM_CHAR    = COM_CHAR_DEFAULT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic       val_in0,
  input  logic       val_in1,
  input  logic       val_in2,
  input  logic       val_in3,
  output logic       in_sample,
  output logic       tx_out,
  output logic       tx_frame,
  output logic       tx_active
);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [FRAME_BITS-1:0] frame;
  logic                  load;
  phy_state_e            state;
  phy_state_e            frame_state;

  assign load = (cnt_q == CNT_W'(FRAME_BITS - 1));

`ifdef PHY_TX_SYNC_PREAMBLE_EN
  phy_state_e state_q;
  logic [3:0] sync_cnt_q;
  logic       sync_done;

  // The reset frame is not counted: SYNC_FRAMES further COM frames follow it.
  assign sync_done = (sync_cnt_q == 4'(SYNC_FRAMES));

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SYNC;
      sync_cnt_q <= '0;
    end else if (load && state_q == SYNC) begin
      if (sync_done) begin
        state_q <= DATA;
      end else begin
        sync_cnt_q <= sync_cnt_q + 4'd1;
      end
    end
  end

  assign state = state_q;
  // The frame loaded on the leaving edge already carries lane data.
  assign frame_state = (state_q == SYNC && load && sync_done) ? DATA : state_q;
`else
  assign state       = DATA;
  assign frame_state = DATA;
`endif

  phy_tx_frame_builder #(
    .COM_CHAR (COM_CHAR)
  ) u_frame_builder (
    .lane_data_i  ({in3, in2, in1, in0}),
    .lane_valid_i ({val_in3, val_in2, val_in1, val_in0}),
    .state_i      (frame_state),
    .frame_o      (frame)
  );

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sh_d  = load ? frame : {sh_q[FRAME_BITS-2:0], 1'b0};
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      cnt_q <= '0;
      sh_q  <= com_frame(COM_CHAR);
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

  assign tx_out    = sh_q[FRAME_BITS-1];
  assign tx_frame  = (cnt_q == '0);
  assign in_sample = load;
  assign tx_active = (state == DATA);

endmodule
